// File: rtl/fetch_queue.sv
// Instruction prefetch queue feeding the IF/ID register: borrows idle memory cycles to fetch ahead,
// holds {inst, pc} pairs, flushes on redirect and stops fetching once an EBREAK has been queued.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter int          ADDR_W   = 12,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_busy,
    input  logic                         redirect,
    input  logic [31:0]                  redirect_pc,
    output logic                         imem_req,
    output logic [ADDR_W-1:0]            imem_addr,
    input  logic [31:0]                  imem_rdata,
    input  logic                         deq,
    output logic                         inst_valid,
    output logic [31:0]                  inst,
    output logic [31:0]                  inst_pc,
    output logic [31:0]                  inst_pc4,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW:0] DepthLim = (CW+1)'(DEPTH);
    localparam logic [31:0] NopInst  = 32'h0000_0013;

    logic [31:0]   instMem [DEPTH];
    logic [31:0]   pcMem   [DEPTH];

    logic [PW-1:0] headQ, headD;
    logic [PW-1:0] tailQ, tailD;
    logic [CW-1:0] countQ, countD;
    logic [31:0]   fetchPcQ, fetchPcD;
    logic          inflightQ, inflightD;
    logic [31:0]   inflightPcQ, inflightPcD;
    logic          haltedQ, haltedD;

    logic          enq;
    logic          deqFire;
    logic          incomingEbreak;
    logic [CW:0]   reserved;
    logic [31:0]   redirectTarget;

    assign redirectTarget = redirect_pc & 32'hFFFF_FFFC;
    assign reserved       = {1'b0, countQ} + {{CW{1'b0}}, inflightQ};

    // A redirect discards the response arriving in the same cycle and ignores decode's dequeue.
    assign enq            = inflightQ & ~redirect;
    assign deqFire        = deq & (countQ != '0) & ~redirect;

    // The EBREAK being written this edge already blocks the next request, so nothing past it is fetched.
    assign incomingEbreak = enq & (imem_rdata[6:0] == 7'b1110011) & imem_rdata[20];

    assign imem_req  = ~rst & ~haltedQ & ~incomingEbreak & ~mem_busy & ~redirect & (reserved < DepthLim);
    assign imem_addr = fetchPcQ[ADDR_W-1:0];

    assign inst_valid = (countQ != '0);
    assign inst       = inst_valid ? instMem[headQ] : NopInst;
    assign inst_pc    = inst_valid ? pcMem[headQ] : 32'h0;
    assign inst_pc4   = inst_valid ? pcMem[headQ] + 32'd4 : 32'h0;
    assign count      = countQ;

    always_comb begin
        headD       = headQ;
        tailD       = tailQ;
        countD      = countQ;
        fetchPcD    = fetchPcQ;
        inflightD   = 1'b0;
        inflightPcD = inflightPcQ;
        haltedD     = haltedQ;

        if (redirect) begin
            headD    = '0;
            tailD    = '0;
            countD   = '0;
            fetchPcD = redirectTarget;
            haltedD  = 1'b0;
        end else begin
            if (enq) begin
                tailD = tailQ + PW'(1);
            end
            if (deqFire) begin
                headD = headQ + PW'(1);
            end
            if (enq && !deqFire) begin
                countD = countQ + CW'(1);
            end else if (!enq && deqFire) begin
                countD = countQ - CW'(1);
            end
            if (incomingEbreak) begin
                haltedD = 1'b1;
            end
            if (imem_req) begin
                fetchPcD    = fetchPcQ + 32'd4;
                inflightD   = 1'b1;
                inflightPcD = fetchPcQ;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            headQ       <= '0;
            tailQ       <= '0;
            countQ      <= '0;
            fetchPcQ    <= RESET_PC;
            inflightQ   <= 1'b0;
            inflightPcQ <= RESET_PC;
            haltedQ     <= 1'b0;
        end else begin
            headQ       <= headD;
            tailQ       <= tailD;
            countQ      <= countD;
            fetchPcQ    <= fetchPcD;
            inflightQ   <= inflightD;
            inflightPcQ <= inflightPcD;
            haltedQ     <= haltedD;
        end
    end

    // Payload storage needs no reset: entries are only visible through countQ.
    always_ff @(posedge clk) begin
        if (enq) begin
            instMem[tailQ] <= imem_rdata;
            pcMem[tailQ]   <= inflightPcQ;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue, checked every cycle against a queue-based model
// of the prefetch behaviour (reservation, one-cycle memory latency, halt on EBREAK, redirect flush).
module tb_fetch_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_busy = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        deq = 1'b0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic [2:0]  count;

    int testsRun = 0;
    int testsFailed = 0;

    logic [31:0] memArr [1024];

    entry_t      mQ[$];
    entry_t      mPend[$];
    logic [31:0] mFetchPc;
    bit          mHalted;

    bit          sawReq12;
    int          maxCount;

    fetch_queue #(.DEPTH(DEPTH), .ADDR_W(12), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .mem_busy(mem_busy), .redirect(redirect), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .deq(deq),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4), .count(count)
    );

    always #5 clk = ~clk;

    function automatic bit isEb(input logic [31:0] w);
        return (w[6:0] == 7'h73) && w[20];
    endfunction

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        return memArr[addr[11:2]];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        mQ.delete();
        mPend.delete();
        mFetchPc = 32'h0;
        mHalted  = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_req"}, {31'b0, imem_req}, 32'h0);
        checkOutput({tag, "_addr"}, {20'b0, imem_addr}, 32'h0);
        checkOutput({tag, "_valid"}, {31'b0, inst_valid}, 32'h0);
        checkOutput({tag, "_inst"}, inst, 32'h13);
        checkOutput({tag, "_pc"}, inst_pc, 32'h0);
        checkOutput({tag, "_pc4"}, inst_pc4, 32'h0);
        checkOutput({tag, "_count"}, {29'b0, count}, 32'h0);
    endtask

    // Asserts rst part-way through a cycle, checks outputs clear at once, releases after a negedge.
    task automatic doReset(input int holdCycles);
        #3;
        rst = 1'b1;
        mem_busy = 1'b0;
        redirect = 1'b0;
        deq = 1'b0;
        modelReset();
        #1;
        checkResetOutputs("rst");
        repeat (holdCycles) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        imem_rdata = $urandom();
    endtask

    // One clock cycle: apply inputs, compare against the model, then advance model and memory.
    task automatic applyStimulus(input logic busyIn, input logic redirIn, input logic [31:0] rpcIn,
                                 input logic deqIn);
        logic        expReq;
        logic [31:0] reqAddr;
        int          sz;
        mem_busy = busyIn;
        redirect = redirIn;
        redirect_pc = rpcIn;
        deq = deqIn;
        #1;
        sz = mQ.size();
        expReq = !mHalted && !busyIn && !redirIn && (mQ.size() + mPend.size() < DEPTH)
                 && !(mPend.size() != 0 && isEb(mPend[0].inst));
        checkOutput("imem_req", {31'b0, imem_req}, {31'b0, expReq});
        checkOutput("imem_addr", {20'b0, imem_addr}, {20'b0, mFetchPc[11:0]});
        checkOutput("count", {29'b0, count}, sz);
        checkOutput("inst_valid", {31'b0, inst_valid}, (sz != 0) ? 32'h1 : 32'h0);
        checkOutput("inst", inst, (sz != 0) ? mQ[0].inst : 32'h13);
        checkOutput("inst_pc", inst_pc, (sz != 0) ? mQ[0].pc : 32'h0);
        checkOutput("inst_pc4", inst_pc4, (sz != 0) ? mQ[0].pc + 32'd4 : 32'h0);
        if (imem_req && imem_addr == 12'h00c) sawReq12 = 1'b1;
        if (int'(count) > maxCount) maxCount = int'(count);
        reqAddr = mFetchPc;
        @(posedge clk);
        if (redirIn) begin
            mQ.delete();
            mPend.delete();
            mHalted  = 1'b0;
            mFetchPc = rpcIn & 32'hFFFF_FFFC;
        end else begin
            if (deqIn && mQ.size() > 0) void'(mQ.pop_front());
            if (mPend.size() > 0) begin
                mQ.push_back(mPend[0]);
                if (isEb(mPend[0].inst)) mHalted = 1'b1;
                mPend.delete();
            end
            if (expReq) begin
                mPend.push_back('{inst: memWord(reqAddr), pc: reqAddr});
                mFetchPc = mFetchPc + 32'd4;
            end
        end
        #1;
        imem_rdata = expReq ? memWord(reqAddr) : $urandom();
        @(negedge clk);
    endtask

    task automatic loadSequentialMem();
        for (int i = 0; i < 1024; i++) memArr[i] = 32'h1000 + i;
    endtask

    task automatic loadRandomMem();
        logic [31:0] w;
        for (int i = 0; i < 1024; i++) begin
            w = $urandom();
            if (isEb(w)) w[20] = 1'b0;
            if ($urandom_range(39) == 0) w = 32'h0010_0073;
            memArr[i] = w;
        end
    endtask

    initial begin
        logic [31:0] rpc;
        modelReset();
        loadSequentialMem();
        #1;
        checkResetOutputs("init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back fill with decode stalled.
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t1_count", {29'b0, count}, 32'd4);
        checkOutput("t1_inst", inst, 32'h1000);
        checkOutput("t1_pc4", inst_pc4, 32'h4);

        // Streaming with decode consuming every cycle, then a 3-cycle data-port stall.
        doReset(1);
        maxCount = 0;
        repeat (2) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("t2_maxcount", (maxCount <= 2) ? 32'h1 : 32'h0, 32'h1);
        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect with three entries queued and one in flight.
        doReset(1);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t4_pre_count", {29'b0, count}, 32'd3);
        applyStimulus(1'b0, 1'b1, 32'h103, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t4_inst_pc", inst_pc, 32'h100);

        // EBREAK at address 8 halts fetching; redirect resumes it.
        loadSequentialMem();
        memArr[2] = 32'h0010_0073;
        doReset(1);
        sawReq12 = 1'b0;
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("t5_count", {29'b0, count}, 32'd3);
        repeat (14) applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("t5_no_req12", {31'b0, sawReq12}, 32'h0);
        checkOutput("t5_drained", {31'b0, inst_valid}, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0);
        checkOutput("t5_resume_addr", {20'b0, imem_addr}, 32'h40);
        repeat (4) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);

        // Reset while full, then wrap of fetch_pc past 2^32.
        loadSequentialMem();
        repeat (4) applyStimulus(1'b0, 1'b1, 32'h0, 1'b0);
        repeat (6) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        doReset(2);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b0, 32'h0, ($urandom_range(1) == 1));

        // Random traffic over memory seeded with occasional EBREAKs.
        loadRandomMem();
        doReset(1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(499) == 0) begin
                doReset(1);
            end else begin
                rpc = ($urandom_range(15) == 0) ? $urandom() : {20'b0, 12'($urandom())};
                applyStimulus($urandom_range(9) < 3, $urandom_range(19) == 0, rpc,
                              $urandom_range(9) < 6);
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
